apb_requester: RTL and testbench

//  APB4 requester (initiator): converts single commands on a valid/ready command port into APB transfers.

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_requester.sv | 150 +++++++++++++++
 tb/tb_apb_requester.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB types: requester state encoding and the command/response records
// used by the requester, the completer and their benches.
package apb_pkg;

    localparam int APB_AWIDTH = 12;
    localparam int APB_DWIDTH = 32;
    localparam int APB_SWIDTH = APB_DWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_e;

    typedef struct packed {
        logic [APB_AWIDTH-1:0] addr;
        logic                  write;
        logic [APB_DWIDTH-1:0] wdata;
        logic [APB_SWIDTH-1:0] strb;
        logic [2:0]            prot;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DWIDTH-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_requester.sv
// APB4 requester: one command in, one APB transfer out, one response back,
// with a bounded wait on PREADY so a dead completer cannot stall the master.
module apb_requester
    import apb_pkg::*;
#(
    parameter int AWIDTH  = APB_AWIDTH,
    parameter int DWIDTH  = APB_DWIDTH,
    parameter int SWIDTH  = DWIDTH / 8,
    parameter int TIMEOUT = 256
) (
    input  logic              i_ck,
    input  logic              i_rst,
    // Handshakes: a beat moves on a rising edge where valid and ready are both
    // high; the source holds valid and payload stable until then.
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [AWIDTH-1:0] i_cmd_addr,
    input  logic              i_cmd_write,
    input  logic [DWIDTH-1:0] i_cmd_wdata,
    input  logic [SWIDTH-1:0] i_cmd_strb,
    input  logic [2:0]        i_cmd_prot,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DWIDTH-1:0] o_rsp_rdata,
    output logic              o_rsp_slverr,
    output logic              o_rsp_timeout,
    output logic              o_sel,
    output logic              o_enable,
    output logic              o_write,
    output logic [AWIDTH-1:0] o_addr,
    output logic [DWIDTH-1:0] o_wdata,
    output logic [SWIDTH-1:0] o_strb,
    output logic [2:0]        o_prot,
    input  logic [DWIDTH-1:0] i_rdata,
    input  logic              i_ready,
    input  logic              i_slverr,
    output apb_req_state_e    o_state
);

    // Counter is kept at least one bit wide so TIMEOUT=0 (wait forever) elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    apb_req_state_e state_q, state_d;
    apb_cmd_t       cmd_q, cmd_d;
    apb_rsp_t       rsp_q, rsp_d;
    logic           sel_q, sel_d;
    logic           enable_q, enable_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           end_xfer;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_d       = rsp_q;
        sel_d       = sel_q;
        enable_d    = enable_q;
        rsp_valid_d = rsp_valid_q;
        cnt_d       = cnt_q;
        end_xfer    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    cmd_d.addr  = i_cmd_addr;
                    cmd_d.write = i_cmd_write;
                    cmd_d.wdata = i_cmd_wdata;
                    cmd_d.strb  = i_cmd_write ? i_cmd_strb : '0;
                    cmd_d.prot  = i_cmd_prot;
                    sel_d       = 1'b1;
                    enable_d    = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                enable_d = 1'b1;
                cnt_d    = '0;
                state_d  = ACCESS;
            end
            ACCESS: begin
                if (i_ready) begin
                    rsp_d.rdata   = cmd_q.write ? '0 : i_rdata;
                    rsp_d.slverr  = i_slverr;
                    rsp_d.timeout = 1'b0;
                    end_xfer      = 1'b1;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    rsp_d.rdata   = '0;
                    rsp_d.slverr  = 1'b1;
                    rsp_d.timeout = 1'b1;
                    end_xfer      = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Address/data/control stay put after the beat; only the strobe is cleared.
        if (end_xfer) begin
            sel_d       = 1'b0;
            enable_d    = 1'b0;
            cmd_d.strb  = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
        end
    end

    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            sel_q       <= 1'b0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            sel_q       <= sel_d;
            enable_q    <= enable_d;
            rsp_valid_q <= rsp_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_cmd_ready   = (state_q == IDLE) && !i_rst;
    assign o_sel         = sel_q;
    assign o_enable      = enable_q;
    assign o_write       = cmd_q.write;
    assign o_addr        = cmd_q.addr;
    assign o_wdata       = cmd_q.wdata;
    assign o_strb        = cmd_q.strb;
    assign o_prot        = cmd_q.prot;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_q.rdata;
    assign o_rsp_slverr  = rsp_q.slverr;
    assign o_rsp_timeout = rsp_q.timeout;
    assign o_state       = state_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: a behavioural APB completer plus a word-memory
// reference model feeding an expected-response queue.
module tb_apb_requester;
    import apb_pkg::*;

    localparam int TO = 8;

    logic        i_ck = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [11:0] i_cmd_addr;
    logic        i_cmd_write;
    logic [31:0] i_cmd_wdata;
    logic [3:0]  i_cmd_strb;
    logic [2:0]  i_cmd_prot;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_slverr;
    logic        o_rsp_timeout;
    logic        o_sel, o_enable, o_write;
    logic [11:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_strb;
    logic [2:0]  o_prot;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        i_slverr;
    apb_req_state_e o_state;

    int n_cmp  = 0;
    int n_fail = 0;

    apb_requester #(.AWIDTH(12), .DWIDTH(32), .SWIDTH(4), .TIMEOUT(TO)) dut (
        .i_ck(i_ck), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr), .i_cmd_write(i_cmd_write),
        .i_cmd_wdata(i_cmd_wdata), .i_cmd_strb(i_cmd_strb), .i_cmd_prot(i_cmd_prot),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_slverr(o_rsp_slverr), .o_rsp_timeout(o_rsp_timeout),
        .o_sel(o_sel), .o_enable(o_enable), .o_write(o_write),
        .o_addr(o_addr), .o_wdata(o_wdata), .o_strb(o_strb), .o_prot(o_prot),
        .i_rdata(i_rdata), .i_ready(i_ready), .i_slverr(i_slverr),
        .o_state(o_state)
    );

    // ---------------- clock ----------------
    always #5 i_ck = ~i_ck;

    // ---------------- completer model ----------------
    // Errors above 0xF00; garbage on PRDATA/PSLVERR whenever PREADY is low.
    logic        dead = 1'b0;
    int          stall_cycles = 0;
    int          acc_cnt = 0;
    bit   [31:0] cmem [0:1023];

    assign i_ready  = o_sel && o_enable && !dead && (acc_cnt >= stall_cycles);
    assign i_rdata  = i_ready ? cmem[o_addr[11:2]] : 32'hBAD0_BAD0;
    assign i_slverr = i_ready ? (o_addr >= 12'hF00) : 1'b1;

    always @(posedge i_ck) begin
        if (i_rst || !(o_sel && o_enable) || i_ready) acc_cnt <= 0;
        else acc_cnt <= acc_cnt + 1;
        if (o_sel && o_enable && i_ready && o_write && (o_addr < 12'hF00))
            for (int b = 0; b < 4; b++)
                if (o_strb[b]) cmem[o_addr[11:2]][8*b +: 8] <= o_wdata[8*b +: 8];
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] model_mem [int];
    logic [33:0] exp_q [$];   // {rdata, slverr, timeout}

    function automatic logic [33:0] model_xfer(logic [11:0] addr, logic wr,
                                               logic [31:0] wdata, logic [3:0] strb);
        logic [31:0] old, mask;
        int idx;
        idx = int'(addr) / 4;
        if (dead) return {32'h0, 1'b1, 1'b1};
        if (addr >= 12'hF00) return {32'h0, 1'b1, 1'b0};
        old = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        if (!wr) return {old, 1'b0, 1'b0};
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
        model_mem[idx] = (old & ~mask) | (wdata & mask);
        return {32'h0, 1'b0, 1'b0};
    endfunction

    // ---------------- driver ----------------
    task automatic do_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot,
                           input int stall, input int hold, input string name);
        int n, cycles, acc, acc_exp;
        logic [33:0] exp, got;
        stall_cycles = stall;
        exp_q.push_back(model_xfer(addr, wr, wdata, strb));
        acc_exp = dead ? TO : stall + 1;

        @(negedge i_ck);
        i_cmd_addr = addr; i_cmd_write = wr; i_cmd_wdata = wdata;
        i_cmd_strb = strb; i_cmd_prot = prot; i_cmd_valid = 1'b1;
        n = 0;
        while (!o_cmd_ready && n < 50) begin @(negedge i_ck); n++; end
        n_cmp++;
        if (!o_cmd_ready) begin
            n_fail++; $display("FAIL %s cmd_accept: o_cmd_ready=%b required 1", name, o_cmd_ready);
        end
        @(posedge i_ck); #1;
        i_cmd_valid = 1'b0;

        cycles = 0; acc = 0;
        while (!o_rsp_valid && cycles < 100) begin
            @(negedge i_ck);
            cycles++;
            if (o_sel) begin
                n_cmp++;
                if ({o_addr, o_write, o_wdata, o_prot, o_strb, o_cmd_ready} !==
                    {addr, wr, wdata, prot, (wr ? strb : 4'h0), 1'b0}) begin
                    n_fail++;
                    $display("FAIL %s bus_hold: addr=%h wr=%b wd=%h prot=%h strb=%h rdy=%b required addr=%h wr=%b wd=%h prot=%h strb=%h rdy=0",
                             name, o_addr, o_write, o_wdata, o_prot, o_strb, o_cmd_ready,
                             addr, wr, wdata, prot, (wr ? strb : 4'h0));
                end
                if (o_enable) acc++;
            end
        end
        n_cmp++;
        if (!o_rsp_valid || cycles != acc_exp + 2 || acc != acc_exp) begin
            n_fail++;
            $display("FAIL %s timing: rsp_valid=%b cycles=%0d access=%0d required 1 %0d %0d",
                     name, o_rsp_valid, cycles, acc, acc_exp + 2, acc_exp);
        end
        n_cmp++;
        if ({o_sel, o_enable, o_strb} !== 6'b0) begin
            n_fail++;
            $display("FAIL %s bus_idle: sel=%b en=%b strb=%h required 0 0 0", name, o_sel, o_enable, o_strb);
        end
        exp = exp_q.pop_front();
        got = {o_rsp_rdata, o_rsp_slverr, o_rsp_timeout};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s response: rdata=%h slverr=%b timeout=%b required %h %b %b",
                     name, got[33:2], got[1], got[0], exp[33:2], exp[1], exp[0]);
        end

        // Back-pressure: a pending command must not start a new beat.
        if (hold > 0) begin
            i_cmd_addr = 12'h0AC; i_cmd_write = 1'b1; i_cmd_valid = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge i_ck);
            n_cmp++;
            if ({o_rsp_valid, o_rsp_rdata, o_rsp_slverr, o_rsp_timeout, o_cmd_ready, o_sel} !==
                {1'b1, exp, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL %s rsp_hold: valid=%b rdata=%h err=%b to=%b cmd_rdy=%b sel=%b required 1 %h %b %b 0 0",
                         name, o_rsp_valid, o_rsp_rdata, o_rsp_slverr, o_rsp_timeout,
                         o_cmd_ready, o_sel, exp[33:2], exp[1], exp[0]);
            end
        end
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge i_ck); #1;
        i_rsp_ready = 1'b0;
        @(negedge i_ck);
        n_cmp++;
        if ({o_rsp_valid, o_cmd_ready, o_state} !== {1'b0, 1'b1, IDLE}) begin
            n_fail++;
            $display("FAIL %s back_to_idle: rsp_valid=%b cmd_ready=%b state=%0d required 0 1 0",
                     name, o_rsp_valid, o_cmd_ready, o_state);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_rsp_ready = 1'b0;
        i_cmd_addr = '0; i_cmd_write = 1'b0; i_cmd_wdata = '0; i_cmd_strb = '0; i_cmd_prot = '0;
        repeat (3) @(negedge i_ck);
        n_cmp++;
        if ({o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_slverr, o_rsp_timeout, o_sel, o_enable,
             o_write, o_addr, o_wdata, o_strb, o_prot} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b rv=%b sel=%b en=%b addr=%h wd=%h strb=%h required all 0",
                     o_cmd_ready, o_rsp_valid, o_sel, o_enable, o_addr, o_wdata, o_strb);
        end
        i_rst = 1'b0;
        @(negedge i_ck);
        n_cmp++;
        if ({o_cmd_ready, o_state} !== {1'b1, IDLE}) begin
            n_fail++; $display("FAIL reset_release: cmd_ready=%b state=%0d required 1 0", o_cmd_ready, o_state);
        end
    endtask

    task automatic test_write_read();
        do_xfer(12'h010, 1'b1, 32'hDEADBEEF, 4'hF, 3'd2, 0, 0, "wr_full");
        do_xfer(12'h010, 1'b0, 32'h0, 4'hF, 3'd0, 0, 0, "rd_full");
        do_xfer(12'hF04, 1'b0, 32'h0, 4'h0, 3'd1, 0, 0, "rd_slverr");
    endtask

    task automatic test_partial();
        do_xfer(12'h020, 1'b1, 32'hFFFFFFFF, 4'hF, 3'd0, 0, 0, "wr_ones");
        do_xfer(12'h020, 1'b1, 32'h12345678, 4'b0011, 3'd0, 0, 0, "wr_partial");
        do_xfer(12'h020, 1'b0, 32'h0, 4'hF, 3'd0, 0, 0, "rd_partial");
    endtask

    task automatic test_stall();
        do_xfer(12'h030, 1'b1, 32'hA5A5_0F0F, 4'hF, 3'd3, 5, 0, "wr_stall");
        do_xfer(12'h030, 1'b0, 32'h0, 4'h0, 3'd0, 5, 0, "rd_stall");
    endtask

    task automatic test_timeout();
        dead = 1'b1;
        do_xfer(12'h040, 1'b0, 32'h0, 4'h0, 3'd0, 0, 0, "rd_timeout");
        do_xfer(12'h040, 1'b1, 32'h1111_2222, 4'hF, 3'd0, 0, 0, "wr_timeout");
        dead = 1'b0;
        do_xfer(12'h040, 1'b0, 32'h0, 4'h0, 3'd0, 0, 0, "rd_after_timeout");
    endtask

    task automatic test_rsp_hold();
        do_xfer(12'h010, 1'b0, 32'h0, 4'h0, 3'd0, 1, 10, "rd_rsp_hold");
    endtask

    task automatic test_reset_mid();
        int n;
        stall_cycles = 5;
        @(negedge i_ck);
        i_cmd_addr = 12'h050; i_cmd_write = 1'b1; i_cmd_wdata = 32'hCAFE_F00D;
        i_cmd_strb = 4'hF; i_cmd_valid = 1'b1;
        @(posedge i_ck); #1;
        i_cmd_valid = 1'b0;
        n = 0;
        do begin @(negedge i_ck); n++; end while (!o_enable && n < 10);
        i_rst = 1'b1;
        @(negedge i_ck);
        n_cmp++;
        if ({o_sel, o_enable, o_rsp_valid, o_cmd_ready, o_state} !== {4'b0, IDLE}) begin
            n_fail++;
            $display("FAIL reset_mid: sel=%b en=%b rv=%b rdy=%b state=%0d required 0 0 0 0 0",
                     o_sel, o_enable, o_rsp_valid, o_cmd_ready, o_state);
        end
        i_rst = 1'b0;
        @(negedge i_ck);
        n_cmp++;
        if ({o_cmd_ready, o_rsp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_mid_release: rdy=%b rv=%b required 1 0", o_cmd_ready, o_rsp_valid);
        end
        do_xfer(12'h050, 1'b0, 32'h0, 4'h0, 3'd0, 0, 0, "rd_after_reset");
        do_xfer(12'h050, 1'b1, 32'h0BAD_CAFE, 4'b1100, 3'd4, 2, 1, "wr_after_reset");
        do_xfer(12'h050, 1'b0, 32'h0, 4'h0, 3'd0, 0, 0, "rd2_after_reset");
    endtask

    task automatic test_random();
        logic [11:0] addr;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) == 0) addr = 12'hF00 + 12'($urandom_range(0, 15) * 4);
            else addr = 12'($urandom_range(0, 15) * 4);
            do_xfer(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_stall();
        test_timeout();
        test_rsp_hold();
        test_reset_mid();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
